// File: rtl/simd_operand_streamer_if.sv
// Operand bus from the streamer into the SIMD core pad inputs.
// master drives the bus; slave is the SIMD side.
interface simd_operand_streamer_if #(
    parameter int DATA_W = 128
);
    logic              valid_instruction;
    logic              valid_data;
    logic [2:0]        instruction;
    logic [5:0]        data_size;
    logic [DATA_W-1:0] mc_data_in_opa;
    logic [DATA_W-1:0] mc_data_in_opb;

    modport master (
        output valid_instruction,
        output valid_data,
        output instruction,
        output data_size,
        output mc_data_in_opa,
        output mc_data_in_opb
    );

    modport slave (
        input valid_instruction,
        input valid_data,
        input instruction,
        input data_size,
        input mc_data_in_opa,
        input mc_data_in_opb
    );
endinterface

// File: rtl/simd_operand_streamer.sv
// Buffers host operand pairs and streams bursts into the SIMD core.
// Optional XOR checksum of streamed beats: define SIMD_STREAM_CHECKSUM_EN.
module simd_operand_streamer #(
    parameter int DATA_W      = 128,
    parameter int DEPTH       = 16,
    parameter int LEAD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_opa,
    input  logic [DATA_W-1:0]        wr_opb,
    output logic                     wr_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    input  logic                     start,
    input  logic [2:0]               cmd_instruction,
    input  logic [5:0]               cmd_data_size,
    input  logic [$clog2(DEPTH):0]   cmd_beats,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    simd_operand_streamer_if.master  simd,
    output logic [31:0]              checksum
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int CNT_W = $clog2(DEPTH + LEAD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_STREAM,
        S_DONE
    } state_t;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              push, pop;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]     beats_q, beats_d;
    logic [2:0]        instr_q, instr_d;
    logic [5:0]        dsize_q, dsize_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Acceptance looks at the registered count, so a pop cannot free a slot early.
    assign push = wr_en && (count_q < CW'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_d == CW'(DEPTH));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beats_d = beats_q;
        instr_d = instr_q;
        dsize_d = dsize_q;
        opa_d   = '0;
        opb_d   = '0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cmd_beats != '0 && cmd_beats <= count_q) begin
                        instr_d = cmd_instruction;
                        dsize_d = cmd_data_size;
                        beats_d = cmd_beats;
                        vld_d   = 1'b1;
                        busy_d  = 1'b1;
                        if (LEAD_CYCLES > 0) begin
                            state_d = S_LEAD;
                            cnt_d   = CNT_W'(LEAD_CYCLES - 1);
                        end else begin
                            state_d = S_STREAM;
                            pop     = 1'b1;
                            opa_d   = mem_a[rd_ptr_q];
                            opb_d   = mem_b[rd_ptr_q];
                            cnt_d   = CNT_W'(cmd_beats) - CNT_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LEAD: begin
                vld_d  = 1'b1;
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_STREAM;
                    pop     = 1'b1;
                    opa_d   = mem_a[rd_ptr_q];
                    opb_d   = mem_b[rd_ptr_q];
                    cnt_d   = CNT_W'(beats_q) - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STREAM: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    instr_d = '0;
                    dsize_d = '0;
                end else begin
                    vld_d  = 1'b1;
                    busy_d = 1'b1;
                    pop    = 1'b1;
                    opa_d  = mem_a[rd_ptr_q];
                    opb_d  = mem_b[rd_ptr_q];
                    cnt_d  = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q] <= wr_opa;
            mem_b[wr_ptr_q] <= wr_opb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            beats_q  <= '0;
            instr_q  <= '0;
            dsize_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beats_q  <= beats_d;
            instr_q  <= instr_d;
            dsize_q  <= dsize_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef SIMD_STREAM_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    function automatic logic [31:0] fold(input logic [DATA_W-1:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < DATA_W / 32; i++) begin
            r ^= x[i*32 +: 32];
        end
        return r;
    endfunction

    // Cleared on the cycle a burst is accepted, then folded per popped beat.
    always_comb begin
        csum_d = (state_q == S_IDLE && state_d != S_IDLE) ? '0 : csum_q;
        if (pop) begin
            csum_d = csum_d ^ fold(mem_a[rd_ptr_q]) ^ fold(mem_b[rd_ptr_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign wr_full                = full_q;
    assign fifo_count             = count_q;
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign err                    = err_q;
    assign simd.valid_instruction = vld_q;
    assign simd.valid_data        = vld_q;
    assign simd.instruction       = instr_q;
    assign simd.data_size         = dsize_q;
    assign simd.mc_data_in_opa    = opa_q;
    assign simd.mc_data_in_opb    = opb_q;
endmodule

// File: doc/simd_operand_streamer.md
Name: simd_operand_streamer

Overview:
- Memory-controller-side transmitter that drives the SIMD core's operand input interface.
- Buffers host-written 128-bit operand pairs (opa/opb) in an internal FIFO.
- On a start command, streams the pairs one per clock on mc_data_in_opa/opb, framed by valid_instruction/valid_data together with instruction and data_size.
- Sits between the host/test logic and the simd_top_level pad inputs. It replaces hand-driven operand sequencing.

Parameters:
- DATA_W, 128, width of each operand bus.
- DEPTH, 16, FIFO depth in operand pairs (power of 2).
- LEAD_CYCLES, 2, cycles that valid_instruction/valid_data are held high with zero operands before the first beat.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  push one operand pair into the FIFO
- wr_opa  input  DATA_W  operand A to push
- wr_opb  input  DATA_W  operand B to push
- wr_full  output  1  FIFO full; a push is dropped while this is high
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy
- start  input  1  launch a burst (single-cycle pulse)
- cmd_instruction  input  3  opcode for the burst
- cmd_data_size  input  6  data_size value for the burst
- cmd_beats  input  $clog2(DEPTH)+1  number of pairs to stream
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst end
- err  output  1  one-cycle pulse when start is rejected
- valid_instruction  output  1  to SIMD
- valid_data  output  1  to SIMD
- instruction  output  3  to SIMD
- data_size  output  6  to SIMD
- mc_data_in_opa  output  DATA_W  to SIMD
- mc_data_in_opb  output  DATA_W  to SIMD
- checksum  output  32  see Optional Feature

Behaviour:
- All outputs are registered. Reset is synchronous, active-high, and has priority over everything. On reset:
  - every output is 0;
  - FIFO pointers and count are cleared (contents flushed);
  - state returns to IDLE.
- Reset mid-burst aborts the burst: no done pulse, outputs are 0 the next cycle.
- FIFO:
  - A push is accepted when wr_en=1 and the registered count < DEPTH.
  - wr_full = (count == DEPTH).
  - A push while full is dropped silently, even if a pop happens in the same cycle.
  - Simultaneous accepted push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- State machine has four states: IDLE, LEAD, STREAM, DONE.
- IDLE:
  - busy=0, valid_*=0.
  - start=1 with 1 <= cmd_beats <= fifo_count: latch cmd_instruction, cmd_data_size, cmd_beats; go to LEAD. busy is 1 from the next cycle.
  - start=1 with cmd_beats=0 or cmd_beats > fifo_count: pulse err the next cycle and stay in IDLE.
  - start while busy is ignored (no err).
- LEAD:
  - Lasts exactly LEAD_CYCLES cycles (if LEAD_CYCLES=0, go straight to STREAM).
  - valid_instruction=1, valid_data=1.
  - instruction and data_size hold the latched values; mc_data_in_opa/opb = 0.
- STREAM:
  - One FIFO pop per cycle for exactly cmd_beats cycles.
  - mc_data_in_opa/opb carry the popped pair, in push order.
  - valid_instruction=1, valid_data=1.
  - Underrun cannot occur because occupancy was checked at start. Host pushes during STREAM are allowed.
- DONE (one cycle):
  - valid_data=0, valid_instruction=0.
  - Operand buses return to 0.
  - done=1, busy=0; then return to IDLE.
  - A start in the DONE cycle is ignored.
- Latency:
  - start sampled at edge N → valid_* high in cycle N+1.
  - First data beat in cycle N+1+LEAD_CYCLES.
  - Last beat in cycle N+LEAD_CYCLES+cmd_beats.
  - done in the following cycle.
- instruction and data_size are stable for the whole burst. They return to 0 in DONE.

Optional Feature:
- Macro: SIMD_STREAM_CHECKSUM_EN.
- When defined:
  - checksum is a 32-bit XOR accumulator, cleared when a burst is accepted.
  - Each STREAM beat XORs in fold(opa) ^ fold(opb), where fold(x) is the XOR of the four 32-bit lanes of x.
  - The value is stable from DONE until the next accepted start.
- When not defined: checksum is tied to 0 and no accumulator logic exists.

Test Plan:
- Reset, then push 14 pairs (a0=128'h11111111_22222222_55555555_66666666, b0=128'h11111111_22222222_33333333_44444444, ...); start with instruction=3'b101, data_size=15, beats=14.
  - Expect valid_* high for 2 zero-operand cycles, then 14 beats in push order.
  - Expect done one cycle after the last beat; fifo_count=0 afterwards.
- Push 16 pairs, then a 17th → wr_full=1, 17th dropped, fifo_count=16. Stream 16 → all 16 emitted in order; pointer wrap verified by a second 16-pair fill and stream.
- With 3 pairs buffered, start with beats=4 → err pulse, no valid_*, fifo_count stays 3. Start with beats=0 → err pulse.
- Assert reset during beat 5 of a 10-beat burst → next cycle all outputs 0, fifo_count=0, no done; a new push/start then works normally.
- Start pulse during STREAM and during DONE → ignored: no err, beat count unchanged.
- With SIMD_STREAM_CHECKSUM_EN: stream the single pair a=128'hffffffff_ffffffff_ffffffff_ffffffff, b=128'h00000001_00000001_00000001_00000001 → checksum=32'h00000000. Stream the single pair a=128'h12345678_0_0_0, b=0 → checksum=32'h12345678.
